// File: rtl/mac_cluster_seq_if.sv
// Job descriptor, operand handshake, cluster control and packed-pixel write-back of one MAC cluster.
// master: job source / cluster / downstream side; slave: the sequencer.
interface mac_cluster_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = 22,
    parameter int ADDR_WIDTH = 5,
    parameter int PACK       = 4
) ();
    logic                        in_start;
    logic [ADDR_WIDTH-1:0]       in_num_pos;
    logic [7:0]                  in_num_pass;
    logic [4:0]                  in_shift;
    logic                        in_relu;
    logic                        in_add_bias;
    logic                        in_op_valid;
    logic                        out_op_ready;
    logic                        out_cache_clear;
    logic [ADDR_WIDTH-1:0]       out_cache_rd_addr;
    logic [ADDR_WIDTH-1:0]       out_cache_wr_addr;
    logic                        out_done;
    logic                        out_relu;
    logic                        out_add_bias;
    logic signed [SUM_WIDTH-1:0] in_total_sum;
    logic [PACK*DATA_WIDTH-1:0]  out_pix_data;
    logic                        out_pix_valid;
    logic                        in_pix_ready;
    logic                        out_busy;
    logic                        out_job_done;

    modport master (
        output in_start, in_num_pos, in_num_pass, in_shift, in_relu, in_add_bias,
               in_op_valid, in_total_sum, in_pix_ready,
        input  out_op_ready, out_cache_clear, out_cache_rd_addr, out_cache_wr_addr,
               out_done, out_relu, out_add_bias, out_pix_data, out_pix_valid,
               out_busy, out_job_done
    );

    modport slave (
        input  in_start, in_num_pos, in_num_pass, in_shift, in_relu, in_add_bias,
               in_op_valid, in_total_sum, in_pix_ready,
        output out_op_ready, out_cache_clear, out_cache_rd_addr, out_cache_wr_addr,
               out_done, out_relu, out_add_bias, out_pix_data, out_pix_valid,
               out_busy, out_job_done
    );
endinterface

// File: rtl/mac_cluster_seq.sv
// Sequencer for a 64-lane MAC cluster: walks passes/positions, captures last-pass sums,
// requantizes them to signed bytes and packs them into words through a 2-entry FIFO.
module mac_cluster_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = DATA_WIDTH*2+6,
    parameter int ADDR_WIDTH = 5,
    parameter int PACK       = 4
) (
    input  logic             clk,
    input  logic             rst,
    mac_cluster_seq_if.slave bus
);
    localparam int LANE_W = $clog2(PACK);
    localparam int WORD_W = PACK*DATA_WIDTH;
    localparam logic signed [SUM_WIDTH:0] QMAX = (SUM_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [SUM_WIDTH:0] QMIN = ~QMAX;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK-1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] num_pos_q, k_q;
    logic [7:0]            num_pass_q, p_q;
    logic [4:0]            shift_q;
    logic                  relu_q, bias_q, inflight_q;
    logic [LANE_W-1:0]     lane_q, lane_d, beat_lane;
    logic [WORD_W-1:0]     pack_q, pack_d, push_word;
    logic [WORD_W-1:0]     fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;
    logic [2:0]            words_ahead;
    logic                  start, last_pass, last_beat, stall, issue, push, pop;
    logic signed [SUM_WIDTH:0] sum_ext, rnd, shifted;
    logic [DATA_WIDTH-1:0] q8;

    assign start     = (state_q == IDLE) && bus.in_start;
    assign last_pass = (p_q == num_pass_q);
    assign last_beat = last_pass && (k_q == num_pos_q);

    // A word-completing beat may only issue if its word is guaranteed a FIFO slot.
    assign beat_lane   = lane_q + LANE_W'(inflight_q);
    assign words_ahead = 3'(count_q) + 3'(inflight_q && (lane_q == LAST_LANE));
    assign stall       = last_pass && (beat_lane == LAST_LANE) && (words_ahead >= 3'd2);
    assign issue       = (state_q == RUN) && bus.in_op_valid && !stall;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_start) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (issue && last_beat) state_d = FLUSH;
            FLUSH:   if (!inflight_q && (lane_q == '0) && (count_d == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.out_busy          = (state_q != IDLE);
        bus.out_cache_clear   = (state_q == CLEAR);
        bus.out_job_done      = (state_q == DONE);
        bus.out_op_ready      = issue;
        bus.out_cache_rd_addr = k_q;
        bus.out_cache_wr_addr = k_q;
        bus.out_add_bias      = issue && bias_q && (p_q == '0);
        bus.out_done          = issue && last_pass;
        bus.out_relu          = issue && relu_q && last_pass;
    end

    always_comb begin
        sum_ext = {bus.in_total_sum[SUM_WIDTH-1], bus.in_total_sum};
        rnd     = '0;
        if (shift_q != '0) rnd = (SUM_WIDTH+1)'(1) <<< (shift_q - 5'd1);
        shifted = (sum_ext + rnd) >>> shift_q;
        if (shifted > QMAX)      q8 = QMAX[DATA_WIDTH-1:0];
        else if (shifted < QMIN) q8 = QMIN[DATA_WIDTH-1:0];
        else                     q8 = shifted[DATA_WIDTH-1:0];
    end

    assign bus.out_pix_valid = (count_q != '0);
    assign bus.out_pix_data  = bus.out_pix_valid ? fifo_q[rd_ptr_q] : '0;
    assign pop               = bus.out_pix_valid && bus.in_pix_ready;

    // Partial words are only flushed once the FIFO has room, since they bypass the stall rule.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        lane_d    = lane_q;
        pack_d    = pack_q;
        if (inflight_q) begin
            pack_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = q8;
            if (lane_q == LAST_LANE) begin
                push      = 1'b1;
                push_word = pack_d;
                pack_d    = '0;
                lane_d    = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end else if ((state_q == FLUSH) && (lane_q != '0) && ((count_q != 2'd2) || pop)) begin
            push      = 1'b1;
            push_word = pack_q;
            pack_d    = '0;
            lane_d    = '0;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_pos_q  <= '0;
            num_pass_q <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            bias_q     <= 1'b0;
            k_q        <= '0;
            p_q        <= '0;
            inflight_q <= 1'b0;
            lane_q     <= '0;
            pack_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            if (start) begin
                num_pos_q  <= bus.in_num_pos;
                num_pass_q <= bus.in_num_pass;
                shift_q    <= bus.in_shift;
                relu_q     <= bus.in_relu;
                bias_q     <= bus.in_add_bias;
                k_q        <= '0;
                p_q        <= '0;
            end else if (issue) begin
                if (k_q == num_pos_q) begin
                    k_q <= '0;
                    p_q <= p_q + 8'd1;
                end else begin
                    k_q <= k_q + ADDR_WIDTH'(1);
                end
            end
            inflight_q <= issue && last_pass;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_word;
    end
endmodule
